reg_alu_stage: RTL and testbench
================================

REG_ALU_STAGE -- requirements
Module: reg_alu_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, register-file address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid_in input 1 and cmd_ready_out output 1: command handshake.
REQ-006 SHALL have ports cmd_op_in input 3, cmd_rd_in/cmd_rs1_in/cmd_rs2_in input ADDR_W each, cmd_imm_in input DATA_W: command fields.
REQ-007 SHALL have ports read_addr0_out/read_addr1_out output ADDR_W, read_out output 1, read_data0_in/read_data1_in input DATA_W: file read ports, combinational data return.
REQ-008 SHALL have ports write_addr_out output ADDR_W, write_out output 1, write_data_out output DATA_W: file write port.
REQ-009 SHALL have port busy_out output 1, high while any command is in EX or WB.
REQ-010 SHALL have port debugen_in input 1, enables per-cycle trace print (simulation only).

Function
REQ-011 SHALL accept a command on a rising edge where cmd_valid_in and cmd_ready_out are both high.
REQ-012 SHALL drive read_addr0_out=cmd_rs1_in, read_addr1_out=cmd_rs2_in combinationally; read_out = cmd_valid_in & cmd_ready_out.
REQ-013 SHALL capture op, rd, imm and both operands into EX registers at the accept edge.
REQ-014 SHALL compute in EX: op 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL by rs2[4:0], 6 SRL (logical) by rs2[4:0], 7 LI (result=imm); arithmetic wraps modulo 2^DATA_W.
REQ-015 SHALL register EX result/rd into WB one edge after accept; write_out high exactly one cycle, from accept edge+1 to accept edge+2; write-back latency 2 cycles.
REQ-016 SHALL sustain one command per cycle when no stall applies.
REQ-017 SHALL detect a hazard when a non-LI command's rs1 or rs2 equals the rd of a valid EX or WB entry.
REQ-018 SHALL, when both EX and WB match the same source, use EX (youngest) value.
REQ-019 SHALL treat LI commands as hazard-free (no source operands read).
REQ-020 SHALL print trace via $write only when debugen_in is high; no functional effect.

Reset
REQ-021 SHALL, while reset is low, hold cmd_ready_out=0, read_out=0, write_out=0, busy_out=0, clear EX/WB valid flags and zero write_addr_out/write_data_out.
REQ-022 SHALL, on reset assertion mid-operation, discard all in-flight commands with no file write.
REQ-023 SHALL raise cmd_ready_out in the first cycle after reset deassertion.

Configuration
REQ-024 SHALL use macro REG_ALU_STAGE_FORWARD_EN to select hazard handling.
REQ-025 SHALL, with REG_ALU_STAGE_FORWARD_EN defined, bypass EX ALU result / WB write data into the captured operand; cmd_ready_out stays high on hazards.
REQ-026 SHALL, without REG_ALU_STAGE_FORWARD_EN, drive cmd_ready_out low while a hazard exists (stall up to 2 cycles), operands always from the file.

Verification
REQ-027 Reset: reset low with cmd_valid_in=1 -> cmd_ready_out=0, write_out=0; release -> cmd_ready_out=1 next cycle.
REQ-028 LI r5,0x1234 then ADD r6=r5+r5 back-to-back -> forward build: no stall, r6 write 0x2468 two cycles after its accept; non-forward build: 2-cycle stall, same final value.
REQ-029 r1=0xFFFFFFFF, r2=1, ADD r3=r1+r2 -> write 0x00000000; SUB r4=r2-r1 -> write 0x00000002.
REQ-030 r1=0x80000000, r2=35, SRL r3 -> shift 3, write 0x10000000; SLL r3 -> write 0x00000000.
REQ-031 EX and WB both writing r7 (LI 1, LI 2), then ADD r8=r7+r7 (forward build) -> write 4 (EX value used).
REQ-032 Reset asserted the cycle after accepting LI r9,0xAA -> no write_out pulse; r9 unchanged.

Source files
------------

// File: rtl/reg_alu_stage.sv
// Two-stage register ALU: command capture into EX, result into WB, which drives the file write port.
// Build option REG_ALU_STAGE_FORWARD_EN: bypass in-flight results instead of stalling on hazards.
`timescale 1ns/1ps
module reg_alu_stage #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_out,
    input  logic [2:0]        cmd_op_in,
    input  logic [ADDR_W-1:0] cmd_rd_in,
    input  logic [ADDR_W-1:0] cmd_rs1_in,
    input  logic [ADDR_W-1:0] cmd_rs2_in,
    input  logic [DATA_W-1:0] cmd_imm_in,
    output logic [ADDR_W-1:0] read_addr0_out,
    output logic [ADDR_W-1:0] read_addr1_out,
    output logic              read_out,
    input  logic [DATA_W-1:0] read_data0_in,
    input  logic [DATA_W-1:0] read_data1_in,
    output logic [ADDR_W-1:0] write_addr_out,
    output logic              write_out,
    output logic [DATA_W-1:0] write_data_out,
    output logic              busy_out,
    input  logic              debugen_in
);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_LI
    } op_e;

    logic              ready_q;
    logic              ex_valid_q;
    op_e               ex_op_q;
    logic [ADDR_W-1:0] ex_rd_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [DATA_W-1:0] ex_a_q, ex_b_q;
    logic [DATA_W-1:0] ex_a_d, ex_b_d;
    logic [DATA_W-1:0] ex_result;
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              accept;
    logic              ex_hit1, ex_hit2, wb_hit1, wb_hit2;

    assign ex_hit1 = ex_valid_q && (ex_rd_q == cmd_rs1_in);
    assign ex_hit2 = ex_valid_q && (ex_rd_q == cmd_rs2_in);
    assign wb_hit1 = wb_valid_q && (wb_rd_q == cmd_rs1_in);
    assign wb_hit2 = wb_valid_q && (wb_rd_q == cmd_rs2_in);

`ifdef REG_ALU_STAGE_FORWARD_EN
    assign cmd_ready_out = ready_q;

    // EX is the youngest producer, so it wins over WB when both match.
    always_comb begin
        ex_a_d = read_data0_in;
        ex_b_d = read_data1_in;
        if (ex_hit1)      ex_a_d = ex_result;
        else if (wb_hit1) ex_a_d = wb_data_q;
        if (ex_hit2)      ex_b_d = ex_result;
        else if (wb_hit2) ex_b_d = wb_data_q;
    end
`else
    logic uses_src;
    logic hazard;

    // LI reads no sources, so it never waits on an in-flight result.
    assign uses_src      = (op_e'(cmd_op_in) != OP_LI);
    assign hazard        = cmd_valid_in && uses_src && (ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2);
    assign cmd_ready_out = ready_q && !hazard;
    assign ex_a_d        = read_data0_in;
    assign ex_b_d        = read_data1_in;
`endif

    assign accept         = cmd_valid_in && cmd_ready_out;
    assign read_out       = accept;
    assign read_addr0_out = cmd_rs1_in;
    assign read_addr1_out = cmd_rs2_in;
    assign write_out      = wb_valid_q;
    assign write_addr_out = wb_rd_q;
    assign write_data_out = wb_data_q;
    assign busy_out       = ex_valid_q || wb_valid_q;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ex_result = '0;
        case (ex_op_q)
            OP_ADD: ex_result = ex_a_q + ex_b_q;
            OP_SUB: ex_result = ex_a_q - ex_b_q;
            OP_AND: ex_result = ex_a_q & ex_b_q;
            OP_OR:  ex_result = ex_a_q | ex_b_q;
            OP_XOR: ex_result = ex_a_q ^ ex_b_q;
            OP_SLL: ex_result = ex_a_q << ex_b_q[4:0];
            OP_SRL: ex_result = ex_a_q >> ex_b_q[4:0];
            OP_LI:  ex_result = ex_imm_q;
            default: ex_result = '0;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q    <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= OP_ADD;
            ex_rd_q    <= '0;
            ex_imm_q   <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            ready_q    <= 1'b1;
            ex_valid_q <= accept;
            if (accept) begin
                ex_op_q  <= op_e'(cmd_op_in);
                ex_rd_q  <= cmd_rd_in;
                ex_imm_q <= cmd_imm_in;
                ex_a_q   <= ex_a_d;
                ex_b_q   <= ex_b_d;
            end
            wb_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                wb_rd_q   <= ex_rd_q;
                wb_data_q <= ex_result;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (debugen_in)
            $write("[reg_alu_stage] t=%0t acc=%b ex_v=%b wb_v=%b wr=%b addr=%0h data=%0h\n",
                   $time, accept, ex_valid_q, wb_valid_q, write_out, write_addr_out, write_data_out);
    end
`endif

endmodule

// File: tb/tb_reg_alu_stage.sv
// Self-checking bench for reg_alu_stage: directed corner cases plus random commands against a
// program-order model with a pending-write list and an external register file.
`timescale 1ns/1ps
module tb_reg_alu_stage;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
`ifdef REG_ALU_STAGE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, SLL = 3'd5, SRL = 3'd6, LI = 3'd7;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid_in;
    logic              cmd_ready_out;
    logic [2:0]        cmd_op_in;
    logic [ADDR_W-1:0] cmd_rd_in, cmd_rs1_in, cmd_rs2_in;
    logic [DATA_W-1:0] cmd_imm_in;
    logic [ADDR_W-1:0] read_addr0_out, read_addr1_out;
    logic              read_out;
    logic [DATA_W-1:0] read_data0_in, read_data1_in;
    logic [ADDR_W-1:0] write_addr_out;
    logic              write_out;
    logic [DATA_W-1:0] write_data_out;
    logic              busy_out;
    logic              debugen_in;

    always #5 clk = ~clk;

    reg_alu_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_op_in(cmd_op_in), .cmd_rd_in(cmd_rd_in), .cmd_rs1_in(cmd_rs1_in),
        .cmd_rs2_in(cmd_rs2_in), .cmd_imm_in(cmd_imm_in),
        .read_addr0_out(read_addr0_out), .read_addr1_out(read_addr1_out), .read_out(read_out),
        .read_data0_in(read_data0_in), .read_data1_in(read_data1_in),
        .write_addr_out(write_addr_out), .write_out(write_out), .write_data_out(write_data_out),
        .busy_out(busy_out), .debugen_in(debugen_in)
    );

    // External register file: combinational read, written on the clock edge
    logic [DATA_W-1:0] rf [256] = '{default: '0};
    assign read_data0_in = rf[read_addr0_out];
    assign read_data1_in = rf[read_addr1_out];
    always @(posedge clk) if (write_out) rf[write_addr_out] <= write_data_out;

    // Reference model: spec_rf holds program-order values, com_rf what has been written back
    typedef struct {
        int                due;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;
    logic [DATA_W-1:0] spec_rf [256] = '{default: '0};
    logic [DATA_W-1:0] com_rf  [256] = '{default: '0};
    wr_t pend[$];
    bit  rdy_ok = 1'b0;
    bit  last_acc = 1'b0;
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_alu(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] imm);
        case (op)
            ADD:  return a + b;
            SUB:  return a - b;
            AND_: return a & b;
            OR_:  return a | b;
            XOR_: return a ^ b;
            SLL:  return a << (b % 32);
            SRL:  return a >> (b % 32);
            default: return imm;
        endcase
    endfunction

    // One clock cycle: check outputs at the falling edge, update the model at the rising edge
    task automatic tick();
        bit acc;
        bit haz;
        bit exp_rdy;
        logic [DATA_W-1:0] res;
        @(negedge clk);
        haz = 1'b0;
        if (cmd_valid_in && cmd_op_in != LI)
            foreach (pend[i])
                if (pend[i].rd == cmd_rs1_in || pend[i].rd == cmd_rs2_in) haz = 1'b1;
        exp_rdy = rdy_ok && reset && !(haz && !FWD);
        if (cmd_valid_in || !reset) check("ready", {31'd0, cmd_ready_out}, {31'd0, exp_rdy});
        check("read_en", {31'd0, read_out}, {31'd0, cmd_valid_in && exp_rdy});
        check("busy", {31'd0, busy_out}, {31'd0, pend.size() != 0});
        if (cmd_valid_in) begin
            check("rd_addr0", {24'd0, read_addr0_out}, {24'd0, cmd_rs1_in});
            check("rd_addr1", {24'd0, read_addr1_out}, {24'd0, cmd_rs2_in});
        end
        if (pend.size() != 0 && pend[0].due == cyc) begin
            check("wr_en", {31'd0, write_out}, 32'd1);
            check("wr_addr", {24'd0, write_addr_out}, {24'd0, pend[0].rd});
            check("wr_data", write_data_out, pend[0].data);
            com_rf[pend[0].rd] = pend[0].data;
            void'(pend.pop_front());
        end else begin
            check("wr_en", {31'd0, write_out}, 32'd0);
        end
        if (!reset) begin
            check("rst_wr_addr", {24'd0, write_addr_out}, 32'd0);
            check("rst_wr_data", write_data_out, 32'd0);
        end
        acc = cmd_valid_in && cmd_ready_out;
        last_acc = acc;
        @(posedge clk);
        cyc++;
        if (acc) begin
            res = model_alu(cmd_op_in, spec_rf[cmd_rs1_in], spec_rf[cmd_rs2_in], cmd_imm_in);
            spec_rf[cmd_rd_in] = res;
            pend.push_back('{due: cyc + 1, rd: cmd_rd_in, data: res});
        end
        if (reset) rdy_ok = 1'b1;
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] rd, input logic [7:0] rs1,
                        input logic [7:0] rs2, input logic [31:0] imm, output int stalls);
        bit done;
        cmd_valid_in = 1'b1;
        cmd_op_in    = op;
        cmd_rd_in    = rd;
        cmd_rs1_in   = rs1;
        cmd_rs2_in   = rs2;
        cmd_imm_in   = imm;
        stalls = 0;
        done   = 1'b0;
        while (!done && stalls < 8) begin
            tick();
            if (last_acc) done = 1'b1;
            else stalls++;
        end
        if (!done) check("accept", {31'd0, last_acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        cmd_valid_in = 1'b0;
        repeat (n) tick();
    endtask

    // Asynchronous reset: in-flight commands are dropped, the model rolls back to written state
    task automatic model_reset();
        pend.delete();
        spec_rf = com_rf;
        rdy_ok  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        reset        = 1'b0;
        debugen_in   = 1'b0;
        cmd_valid_in = 1'b1;
        cmd_op_in    = LI;
        cmd_rd_in    = 8'd5;
        cmd_rs1_in   = 8'd0;
        cmd_rs2_in   = 8'd0;
        cmd_imm_in   = 32'h1234;

        // Reset held with a valid command: nothing accepted or written
        repeat (3) tick();
        reset = 1'b1;

        // LI r5 then dependent ADD r6 = r5 + r5
        send(LI, 8'd5, 8'd0, 8'd0, 32'h1234, st);
        send(ADD, 8'd6, 8'd5, 8'd5, 32'h0, st);
        check("li_add_stalls", st, FWD ? 32'd0 : 32'd2);
        idle(4);
        check("r6_value", rf[6], 32'h2468);

        // Wraparound add and subtract
        send(LI, 8'd1, 8'd0, 8'd0, 32'hFFFF_FFFF, st);
        send(LI, 8'd2, 8'd0, 8'd0, 32'h1, st);
        send(ADD, 8'd3, 8'd1, 8'd2, 32'h0, st);
        send(SUB, 8'd4, 8'd2, 8'd1, 32'h0, st);
        idle(4);
        check("add_wrap", rf[3], 32'h0);
        check("sub_wrap", rf[4], 32'h2);

        // Shift amount taken from the low five bits of rs2
        send(LI, 8'd1, 8'd0, 8'd0, 32'h8000_0000, st);
        send(LI, 8'd2, 8'd0, 8'd0, 32'd35, st);
        send(SRL, 8'd3, 8'd1, 8'd2, 32'h0, st);
        idle(4);
        check("srl_35", rf[3], 32'h1000_0000);
        send(SLL, 8'd3, 8'd1, 8'd2, 32'h0, st);
        idle(4);
        check("sll_35", rf[3], 32'h0);

        // EX and WB both hold r7: the youngest value must be used
        send(LI, 8'd7, 8'd0, 8'd0, 32'd1, st);
        send(LI, 8'd7, 8'd0, 8'd0, 32'd2, st);
        send(ADD, 8'd8, 8'd7, 8'd7, 32'h0, st);
        idle(4);
        check("youngest_r7", rf[8], 32'd4);

        // Reset the cycle after accepting LI r9: no write may appear
        send(LI, 8'd9, 8'd0, 8'd0, 32'h55, st);
        idle(4);
        send(LI, 8'd9, 8'd0, 8'd0, 32'hAA, st);
        cmd_valid_in = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b1;
        idle(3);
        check("r9_kept", rf[9], 32'h55);

        // Random traffic on a small register window to provoke hazards
        debugen_in = 1'b1;
        idle(1);
        debugen_in = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(4) == 0) begin
                idle(1);
            end else begin
                send(3'($urandom_range(7)), 8'($urandom_range(7)), 8'($urandom_range(7)),
                     8'($urandom_range(7)), $urandom, st);
            end
        end
        idle(4);
        for (int r = 0; r < 8; r++) check($sformatf("final_r%0d", r), rf[r], com_rf[r]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
